// File: rtl/fft_pkg.sv
// Shared types and constants for the FFT datapath: complex sample and twiddle
// containers, component indices and the full-precision product width.
package fft_pkg;

    localparam int FFT_DATA_W    = 16;
    localparam int FFT_FRAC_BITS = 15;
    localparam int PROD_W        = FFT_DATA_W + FFT_FRAC_BITS + 2;

    localparam int RE = 0;
    localparam int IM = 1;

    typedef logic [1:0][FFT_DATA_W-1:0]    cplx_t;
    typedef logic [1:0][FFT_FRAC_BITS+1:0] twid_t;

endpackage

// File: rtl/fx_round_sat.sv
// Optional round-half-up arithmetic right shift followed by saturation to OUT_W
// bits; sat_o flags that the value had to be clamped.
module fx_round_sat #(
    parameter int IN_W  = 35,
    parameter int OUT_W = 17,
    parameter int SHIFT = 15
) (
    input  logic signed [IN_W-1:0]  x_i,
    input  logic                    rnd_en_i,
    output logic signed [OUT_W-1:0] y_o,
    output logic                    sat_o
);

    // One guard bit so that adding the rounding constant can never wrap.
    localparam int W = IN_W + 1;
    localparam logic signed [W-1:0] HALF = {{(W-1){1'b0}}, 1'b1} << (SHIFT - 1);

    logic signed [W-1:0] ext_s;
    logic signed [W-1:0] shf_s;

    // Round/shift, then clamp when the bits above the output sign disagree.
    always_comb begin
        ext_s = {x_i[IN_W-1], x_i};
        if (rnd_en_i) begin
            shf_s = (ext_s + HALF) >>> SHIFT;
        end else begin
            shf_s = ext_s;
        end
        if (shf_s[W-1:OUT_W-1] == {(W-OUT_W+1){shf_s[W-1]}}) begin
            sat_o = 1'b0;
            y_o   = shf_s[OUT_W-1:0];
        end else begin
            sat_o = 1'b1;
            y_o   = shf_s[W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
        end
    end

endmodule

// File: rtl/butterfly_pipe.sv
// Three-stage radix-2 DIT butterfly: a' = a + w*b, b' = a - w*b with optional
// conjugate twiddle, /2 scaling, saturation, sticky overflow and a global-stall handshake.
module butterfly_pipe #(
    parameter int DATA_WIDTH = fft_pkg::FFT_DATA_W,
    parameter int FRAC_BITS  = fft_pkg::FFT_FRAC_BITS
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             valid_i,
    output logic                             ready_o,
    input  logic [1:0][DATA_WIDTH-1:0]       a_i,
    input  logic [1:0][DATA_WIDTH-1:0]       b_i,
    input  logic [1:0][FRAC_BITS+1:0]        twid_i,
    input  logic                             inv_i,
    input  logic                             scale_i,
    output logic                             valid_o,
    input  logic                             ready_i,
    output logic [1:0][DATA_WIDTH-1:0]       a_o,
    output logic [1:0][DATA_WIDTH-1:0]       b_o,
    output logic                             ovf_o,
    input  logic                             ovf_clr_i
);
    import fft_pkg::*;

    localparam int P_W = DATA_WIDTH + FRAC_BITS + 2;
    localparam int S_W = P_W + 1;
    localparam int R_W = DATA_WIDTH + 1;
    localparam int A_W = DATA_WIDTH + 2;

    logic en_s;

    // Stage 1 state
    logic                          v1_q, v1_d, inv1_q, inv1_d, scale1_q, scale1_d;
    logic [1:0][DATA_WIDTH-1:0]    a1_q, a1_d;
    logic signed [P_W-1:0]         rr_q, rr_d, ii_q, ii_d, ri_q, ri_d, ir_q, ir_d;
    logic signed [P_W-1:0]         bre_s, bim_s, wre_s, wim_s;

    // Stage 2 state
    logic                          v2_q, v2_d, scale2_q, scale2_d, sat2_q, sat2_d;
    logic [1:0][DATA_WIDTH-1:0]    a2_q, a2_d;
    logic [1:0][R_W-1:0]           rot_q, rot_d;
    logic signed [S_W-1:0]         mix_s [2];
    logic signed [R_W-1:0]         rot_s [2];
    logic [1:0]                    rsat_s;

    // Stage 3 state
    logic                          v3_q, v3_d, ovf_q, ovf_d, set_ovf_s;
    logic [1:0][DATA_WIDTH-1:0]    ao_q, ao_d, bo_q, bo_d;
    logic signed [A_W-1:0]         sum_s [2];
    logic signed [A_W-1:0]         dif_s [2];
    logic signed [DATA_WIDTH-1:0]  sum_r_s [2];
    logic signed [DATA_WIDTH-1:0]  dif_r_s [2];
    logic [1:0]                    ssat_s, dsat_s;

    assign en_s    = !v3_q || ready_i;
    assign ready_o = en_s;
    assign valid_o = v3_q;
    assign a_o     = ao_q;
    assign b_o     = bo_q;
    assign ovf_o   = ovf_q;

    // S1 next state: full-precision partial products of b and w.
    always_comb begin
        bre_s = P_W'($signed(b_i[RE]));
        bim_s = P_W'($signed(b_i[IM]));
        wre_s = P_W'($signed(twid_i[RE]));
        wim_s = P_W'($signed(twid_i[IM]));
        if (en_s) begin
            v1_d     = valid_i;
            inv1_d   = inv_i;
            scale1_d = scale_i;
            a1_d     = a_i;
            rr_d     = bre_s * wre_s;
            ii_d     = bim_s * wim_s;
            ri_d     = bre_s * wim_s;
            ir_d     = bim_s * wre_s;
        end else begin
            v1_d     = v1_q;
            inv1_d   = inv1_q;
            scale1_d = scale1_q;
            a1_d     = a1_q;
            rr_d     = rr_q;
            ii_d     = ii_q;
            ri_d     = ri_q;
            ir_d     = ir_q;
        end
    end

    // S2 rotation: inverse mode multiplies by conj(w).
    always_comb begin
        if (inv1_q) begin
            mix_s[RE] = S_W'(rr_q) + S_W'(ii_q);
            mix_s[IM] = S_W'(ir_q) - S_W'(ri_q);
        end else begin
            mix_s[RE] = S_W'(rr_q) - S_W'(ii_q);
            mix_s[IM] = S_W'(ri_q) + S_W'(ir_q);
        end
    end

    for (genvar c = 0; c < 2; c++) begin : g_rot
        fx_round_sat #(.IN_W(S_W), .OUT_W(R_W), .SHIFT(FRAC_BITS)) u_rot (
            .x_i      (mix_s[c]),
            .rnd_en_i (1'b1),
            .y_o      (rot_s[c]),
            .sat_o    (rsat_s[c])
        );
    end

    // S2 next state.
    always_comb begin
        if (en_s) begin
            v2_d       = v1_q;
            scale2_d   = scale1_q;
            a2_d       = a1_q;
            rot_d[RE]  = rot_s[RE];
            rot_d[IM]  = rot_s[IM];
            sat2_d     = v1_q && (|rsat_s);
        end else begin
            v2_d     = v2_q;
            scale2_d = scale2_q;
            a2_d     = a2_q;
            rot_d    = rot_q;
            sat2_d   = sat2_q;
        end
    end

    for (genvar c = 0; c < 2; c++) begin : g_out
        assign sum_s[c] = A_W'($signed(a2_q[c])) + A_W'($signed(rot_q[c]));
        assign dif_s[c] = A_W'($signed(a2_q[c])) - A_W'($signed(rot_q[c]));

        fx_round_sat #(.IN_W(A_W), .OUT_W(DATA_WIDTH), .SHIFT(1)) u_sum (
            .x_i      (sum_s[c]),
            .rnd_en_i (scale2_q),
            .y_o      (sum_r_s[c]),
            .sat_o    (ssat_s[c])
        );

        fx_round_sat #(.IN_W(A_W), .OUT_W(DATA_WIDTH), .SHIFT(1)) u_dif (
            .x_i      (dif_s[c]),
            .rnd_en_i (scale2_q),
            .y_o      (dif_r_s[c]),
            .sat_o    (dsat_s[c])
        );
    end

    // S3 next state; a saturation landing this cycle outranks a clear request.
    always_comb begin
        set_ovf_s = en_s && v2_q && (sat2_q || (|ssat_s) || (|dsat_s));
        if (en_s) begin
            v3_d      = v2_q;
            ao_d[RE]  = sum_r_s[RE];
            ao_d[IM]  = sum_r_s[IM];
            bo_d[RE]  = dif_r_s[RE];
            bo_d[IM]  = dif_r_s[IM];
        end else begin
            v3_d = v3_q;
            ao_d = ao_q;
            bo_d = bo_q;
        end
        if (set_ovf_s) begin
            ovf_d = 1'b1;
        end else if (ovf_clr_i) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Pipeline registers; reset discards everything in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            v1_q     <= 1'b0;
            inv1_q   <= 1'b0;
            scale1_q <= 1'b0;
            a1_q     <= '0;
            rr_q     <= '0;
            ii_q     <= '0;
            ri_q     <= '0;
            ir_q     <= '0;
            v2_q     <= 1'b0;
            scale2_q <= 1'b0;
            sat2_q   <= 1'b0;
            a2_q     <= '0;
            rot_q    <= '0;
            v3_q     <= 1'b0;
            ao_q     <= '0;
            bo_q     <= '0;
            ovf_q    <= 1'b0;
        end else begin
            v1_q     <= v1_d;
            inv1_q   <= inv1_d;
            scale1_q <= scale1_d;
            a1_q     <= a1_d;
            rr_q     <= rr_d;
            ii_q     <= ii_d;
            ri_q     <= ri_d;
            ir_q     <= ir_d;
            v2_q     <= v2_d;
            scale2_q <= scale2_d;
            sat2_q   <= sat2_d;
            a2_q     <= a2_d;
            rot_q    <= rot_d;
            v3_q     <= v3_d;
            ao_q     <= ao_d;
            bo_q     <= bo_d;
            ovf_q    <= ovf_d;
        end
    end

endmodule

// File: tb/tb_butterfly_pipe.sv
// Scoreboard bench for butterfly_pipe: directed vector table, sticky-overflow
// sequences, randomly stalled stream, full-rate stream and mid-flight reset.
module tb_butterfly_pipe;

    logic              clk_i = 1'b0;
    logic              rst_ni = 1'b0;
    logic              valid_i = 1'b0, ready_o, inv_i = 1'b0, scale_i = 1'b0;
    logic              valid_o, ready_i = 1'b0, ovf_o, ovf_clr_i = 1'b0;
    logic [1:0][15:0]  a_i, b_i, a_o, b_o;
    logic [1:0][16:0]  twid_i;

    butterfly_pipe #(.DATA_WIDTH(16), .FRAC_BITS(15)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .ready_o(ready_o),
        .a_i(a_i), .b_i(b_i), .twid_i(twid_i), .inv_i(inv_i), .scale_i(scale_i),
        .valid_o(valid_o), .ready_i(ready_i), .a_o(a_o), .b_o(b_o),
        .ovf_o(ovf_o), .ovf_clr_i(ovf_clr_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct { int ar, ai, br, bi, wr, wi; bit inv, scale; } in_t;
    typedef struct { int ar, ai, br, bi; bit sat; bit chk_lat; int t_acc; } exp_t;
    typedef struct { in_t x; int ear, eai, ebr, ebi; bit esat; } vec_t;

    exp_t             sbq[$];
    vec_t             tbl[8];
    int               total = 0, bad = 0, cyc = 0;
    bit               exp_ovf = 1'b0, prev_stall = 1'b0, lat_mode = 1'b0;
    logic [1:0][15:0] prev_a, prev_b;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic longint clamp(input longint v, input longint hi, inout bit s);
        if (v > hi) begin s = 1'b1; return hi; end
        if (v < -hi - 64'sd1) begin s = 1'b1; return -hi - 64'sd1; end
        return v;
    endfunction

    function automatic longint fin(input longint v, input bit scale, inout bit s);
        longint t;
        t = scale ? ((v + 64'sd1) >>> 1) : v;
        return clamp(t, 64'sd32767, s);
    endfunction

    // Reference arithmetic written straight from the butterfly equations.
    function automatic exp_t model(input in_t x);
        exp_t   e;
        longint rr, ii, ri, ir, re, im, rre, rim;
        bit     st;
        st = 1'b0;
        rr = longint'(x.br) * longint'(x.wr);
        ii = longint'(x.bi) * longint'(x.wi);
        ri = longint'(x.br) * longint'(x.wi);
        ir = longint'(x.bi) * longint'(x.wr);
        if (x.inv) begin re = rr + ii; im = ir - ri; end
        else       begin re = rr - ii; im = ri + ir; end
        rre = clamp((re + 64'sd16384) >>> 15, 64'sd65535, st);
        rim = clamp((im + 64'sd16384) >>> 15, 64'sd65535, st);
        e.ar = int'(fin(longint'(x.ar) + rre, x.scale, st));
        e.ai = int'(fin(longint'(x.ai) + rim, x.scale, st));
        e.br = int'(fin(longint'(x.ar) - rre, x.scale, st));
        e.bi = int'(fin(longint'(x.ai) - rim, x.scale, st));
        e.sat = st;
        e.chk_lat = 1'b0;
        e.t_acc = 0;
        return e;
    endfunction

    function automatic in_t rnd_in();
        in_t x;
        x.ar = int'($urandom_range(0, 65535)) - 32768;
        x.ai = int'($urandom_range(0, 65535)) - 32768;
        x.br = int'($urandom_range(0, 65535)) - 32768;
        x.bi = int'($urandom_range(0, 65535)) - 32768;
        x.wr = int'($urandom_range(0, 65536)) - 32768;
        x.wi = int'($urandom_range(0, 65536)) - 32768;
        x.inv = 1'($urandom_range(0, 1));
        x.scale = 1'($urandom_range(0, 1));
        return x;
    endfunction

    task automatic pop_check();
        exp_t e;
        if (sbq.size() == 0) begin
            chk("unexpected_output", 1, 0);
        end else begin
            e = sbq.pop_front();
            chk("a_re", int'($signed(a_o[0])), e.ar);
            chk("a_im", int'($signed(a_o[1])), e.ai);
            chk("b_re", int'($signed(b_o[0])), e.br);
            chk("b_im", int'($signed(b_o[1])), e.bi);
            exp_ovf = exp_ovf | e.sat;
            chk("ovf_o", int'(ovf_o), int'(exp_ovf));
            if (e.chk_lat) chk("latency", cyc - e.t_acc, 3);
        end
    endtask

    // One clock: entered and left at a falling edge; inputs apply to the next rising edge.
    task automatic cycle(input bit vin, input bit rin, input in_t x, input bit use_model,
                         input exp_t ex, output bit acc);
        exp_t e;
        if (prev_stall) begin
            chk("hold_valid", int'(valid_o), 1);
            chk("hold_a", int'(a_o), int'(prev_a));
            chk("hold_b", int'(b_o), int'(prev_b));
        end
        valid_i = vin;
        ready_i = rin;
        a_i[0] = x.ar[15:0];  a_i[1] = x.ai[15:0];
        b_i[0] = x.br[15:0];  b_i[1] = x.bi[15:0];
        twid_i[0] = x.wr[16:0]; twid_i[1] = x.wi[16:0];
        inv_i = x.inv;
        scale_i = x.scale;
        #1;
        chk("ready_o", int'(ready_o), int'(!(valid_o && !ready_i)));
        if (valid_o && ready_i) pop_check();
        acc = valid_i && ready_o;
        if (acc) begin
            e = use_model ? model(x) : ex;
            e.t_acc = cyc;
            e.chk_lat = lat_mode;
            sbq.push_back(e);
        end
        prev_stall = valid_o && !ready_i;
        prev_a = a_o;
        prev_b = b_o;
        @(negedge clk_i);
        cyc++;
    endtask

    function automatic exp_t vec_exp(input vec_t v);
        exp_t e;
        e.ar = v.ear; e.ai = v.eai; e.br = v.ebr; e.bi = v.ebi;
        e.sat = v.esat; e.chk_lat = 1'b0; e.t_acc = 0;
        return e;
    endfunction

    task automatic idle(input bit rin);
        in_t  z;
        exp_t ez;
        bit   acc;
        z = '{default: 0};
        ez = '{default: 0};
        cycle(1'b0, rin, z, 1'b1, ez, acc);
    endtask

    task automatic drain();
        for (int n = 0; n < 100 && sbq.size() > 0; n++) idle(1'b1);
        chk("drain_empty", sbq.size(), 0);
    endtask

    task automatic send_vec(input int k, output bit acc);
        cycle(1'b1, 1'b1, tbl[k].x, 1'b0, vec_exp(tbl[k]), acc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        bit   acc;
        int   idx;
        in_t  cur;
        exp_t ez;
        ez = '{default: 0};

        tbl[0] = '{x: '{1000, 0, 500, 0, 32768, 0, 1'b0, 1'b1}, ear: 750, eai: 0, ebr: 250, ebi: 0, esat: 1'b0};
        tbl[1] = '{x: '{0, 0, 0, 1000, 0, -32768, 1'b0, 1'b0}, ear: 1000, eai: 0, ebr: -1000, ebi: 0, esat: 1'b0};
        tbl[2] = '{x: '{0, 0, 0, 1000, 0, 32768, 1'b1, 1'b0}, ear: 1000, eai: 0, ebr: -1000, ebi: 0, esat: 1'b0};
        tbl[3] = '{x: '{32767, 0, 32767, 0, 32768, 0, 1'b0, 1'b0}, ear: 32767, eai: 0, ebr: 0, ebi: 0, esat: 1'b1};
        tbl[4] = '{x: '{32767, 0, 32767, 0, 32768, 0, 1'b0, 1'b1}, ear: 32767, eai: 0, ebr: 0, ebi: 0, esat: 1'b0};
        tbl[5] = '{x: '{0, 0, -32768, -32768, -32768, 32768, 1'b0, 1'b1}, ear: 32767, eai: 0, ebr: -32767, ebi: 0, esat: 1'b1};
        tbl[6] = '{x: '{0, 0, 1, 0, 16384, 0, 1'b0, 1'b1}, ear: 1, eai: 0, ebr: 0, ebi: 0, esat: 1'b0};
        tbl[7] = '{x: '{-3, 5, 0, 0, 0, 0, 1'b0, 1'b1}, ear: -1, eai: 3, ebr: -1, ebi: 3, esat: 1'b0};

        a_i = '0; b_i = '0; twid_i = '0;
        repeat (2) @(negedge clk_i);
        chk("rst_valid_o", int'(valid_o), 0);
        chk("rst_a_o", int'(a_o), 0);
        chk("rst_b_o", int'(b_o), 0);
        chk("rst_ovf_o", int'(ovf_o), 0);
        rst_ni = 1'b1;
        @(negedge clk_i);

        // Directed vectors back to back with latency checks.
        lat_mode = 1'b1;
        for (int k = 0; k < 8; k++) send_vec(k, acc);
        drain();

        ovf_clr_i = 1'b1;
        idle(1'b1);
        ovf_clr_i = 1'b0;
        exp_ovf = 1'b0;
        chk("ovf_clear", int'(ovf_o), 0);

        // Clear requested on the very edge a saturating result registers: set wins.
        send_vec(3, acc);
        idle(1'b1);
        ovf_clr_i = 1'b1;
        idle(1'b1);
        ovf_clr_i = 1'b0;
        idle(1'b1);
        chk("ovf_set_beats_clr", int'(ovf_o), 1);
        ovf_clr_i = 1'b1;
        idle(1'b1);
        ovf_clr_i = 1'b0;
        exp_ovf = 1'b0;
        chk("ovf_clear2", int'(ovf_o), 0);
        drain();

        // Random stream with valid gaps and pseudo-random backpressure.
        lat_mode = 1'b0;
        idx = 0;
        cur = rnd_in();
        for (int n = 0; n < 300 && idx < 8; n++) begin
            cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0), cur, 1'b1, ez, acc);
            if (acc) begin
                idx++;
                cur = rnd_in();
            end
        end
        chk("random_all_sent", idx, 8);
        drain();

        // Full-rate stream: every result exactly three cycles after acceptance.
        lat_mode = 1'b1;
        for (int n = 0; n < 16; n++) begin
            cycle(1'b1, 1'b1, rnd_in(), 1'b1, ez, acc);
            chk("accept_cont", int'(acc), 1);
        end
        drain();

        // Reset with three transactions in flight and a held, overflowed output.
        ovf_clr_i = 1'b1;
        idle(1'b1);
        ovf_clr_i = 1'b0;
        exp_ovf = 1'b0;
        send_vec(3, acc);
        send_vec(0, acc);
        send_vec(0, acc);
        ready_i = 1'b0;
        valid_i = 1'b0;
        #1;
        chk("pre_rst_valid", int'(valid_o), 1);
        chk("pre_rst_ovf", int'(ovf_o), 1);
        #1;
        rst_ni = 1'b0;
        #1;
        chk("mid_rst_valid_o", int'(valid_o), 0);
        chk("mid_rst_a_o", int'(a_o), 0);
        chk("mid_rst_b_o", int'(b_o), 0);
        chk("mid_rst_ovf_o", int'(ovf_o), 0);
        sbq.delete();
        exp_ovf = 1'b0;
        prev_stall = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        send_vec(0, acc);
        drain();
        repeat (4) idle(1'b1);
        chk("post_rst_idle_valid", int'(valid_o), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
